// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and default frame geometry for the SPI master.
package spi_pkg;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  localparam int FRAME_LEN = ADDR_W_DEF + 1 + DATA_W_DEF;
  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, TAIL, GAP} state_t;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period divider, ticks on the last cycle of each CLK_DIV-cycle phase.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge clk)
    if (!rst_n || restart || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-frame SPI master sending addr, rw, data MSB first (mode 0).
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              sclk_pin,
  output logic              cs_pin,
  output logic              mosi_pin,
  input  logic              miso_pin
);
  localparam int FL = ADDR_W + 1 + DATA_W;
  localparam int BW = $clog2(FL);
  state_t            state;
  logic              tick;
  logic              rw;
  logic [FL-1:0]     tx;
  logic [DATA_W-1:0] rx;
  logic [BW-1:0]     bit_cnt;
  logic              last_bit;
  assign req_ready = state == IDLE;
  assign busy      = !req_ready;
  assign last_bit  = bit_cnt == BW'(FL - 1);
  // Divider held at zero while idle so every frame starts phase-aligned.
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (req_ready),
    .tick    (tick)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cs_pin    <= 1'b1;
      sclk_pin  <= 1'b0;
      mosi_pin  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rw        <= 1'b0;
      tx        <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          state   <= SETUP;
          cs_pin  <= 1'b0;
          rw      <= req_rw;
          tx      <= {req_addr, req_rw, req_rw ? {DATA_W{1'b0}} : req_wdata};
          bit_cnt <= '0;
        end
        SETUP: if (tick) begin
          state    <= LOW;
          mosi_pin <= tx[FL-1];
        end
        LOW: if (tick) begin
          state    <= HIGH;
          sclk_pin <= 1'b1;
        end
        HIGH: if (tick) begin
          sclk_pin <= 1'b0;
          if (rw && bit_cnt >= BW'(ADDR_W + 1)) rx <= {rx[DATA_W-2:0], miso_pin};
          if (last_bit) state <= TAIL;
          else begin
            state    <= LOW;
            bit_cnt  <= bit_cnt + 1'b1;
            tx       <= tx << 1;
            mosi_pin <= tx[FL-2];
          end
        end
        TAIL: if (tick) begin
          state     <= GAP;
          cs_pin    <= 1'b1;
          rsp_valid <= 1'b1;
          if (rw) rsp_rdata <= rx;
        end
        GAP: if (tick) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed scoreboard bench with a behavioural SPI memory on the pins.
module tb_spi_master_ctrl;
  localparam int CD = 4;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req_valid = 1'b0, req_rw = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       miso_pin = 1'b0;
  logic       req_ready, rsp_valid, busy, sclk_pin, cs_pin, mosi_pin;
  logic [7:0] rsp_rdata;

  spi_master_ctrl #(.CLK_DIV(CD), .ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin), .miso_pin(miso_pin)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] frame; logic [7:0] rdata;} exp_t;
  exp_t       q[$];
  exp_t       e;
  int         total = 0, bad = 0, rsp_cnt = 0, nb = 0;
  logic [7:0] model_rdata = '0;
  logic [7:0] mem [128];
  logic [15:0] sh = '0, last_frame = '0;
  logic       psclk = 1'b0, rd = 1'b0;
  logic [7:0] obuf = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Memory model: shifts mosi on sclk rise, drives read data on sclk fall.
  always @(negedge clk) begin
    if (cs_pin) nb = 0;
    else begin
      if (sclk_pin && !psclk) begin
        sh = {sh[14:0], mosi_pin};
        nb++;
        if (nb == 16) begin
          last_frame = sh;
          if (!sh[8]) mem[sh[15:9]] = sh[7:0];
        end
      end
      if (!sclk_pin && psclk && nb >= 8 && nb < 16) begin
        if (nb == 8) begin
          rd = sh[0];
          obuf = mem[sh[7:1]];
        end
        if (rd) begin
          miso_pin = obuf[7];
          obuf = obuf << 1;
        end
      end
    end
    psclk = sclk_pin;
    if (rsp_valid) begin
      rsp_cnt++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL rsp_unexpected got=1 want=0");
      end else begin
        e = q.pop_front();
        chk("frame", last_frame, e.frame);
        chk("rdata", rsp_rdata, e.rdata);
      end
    end
  end

  task automatic push_exp(input logic rw, input logic [6:0] a, input logic [7:0] d, input logic [7:0] xr);
    if (rw) model_rdata = xr;
    q.push_back('{frame: {a, rw, rw ? 8'h00 : d}, rdata: model_rdata});
  endtask

  task automatic run_txn(input logic rw, input logic [6:0] a, input logic [7:0] d, input logic [7:0] xr);
    int n, fall, rsp, lows;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
    chk("ready_before_accept", req_ready, 1);
    push_exp(rw, a, d, xr);
    @(negedge clk);
    req_valid = 1'b0; req_rw = ~rw; req_addr = ~a; req_wdata = ~d;
    n = 1; fall = -1; rsp = -1; lows = 0;
    while (!req_ready && n < 400) begin
      if (!cs_pin) begin
        lows++;
        if (fall < 0) fall = n;
      end
      if (rsp_valid && rsp < 0) rsp = n;
      @(negedge clk);
      n++;
    end
    chk("cs_fall_cycle", fall, 1);
    chk("cs_low_cycles", lows, 34 * CD);
    chk("rsp_cycle", rsp, 34 * CD + 1);
    chk("ready_cycle", n, 35 * CD + 1);
  endtask

  initial begin
    int n, rise, fall2, snap;
    bit seen_low;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h7F] = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_cs", cs_pin, 1);
    chk("rst_sclk", sclk_pin, 0);
    chk("rst_mosi", mosi_pin, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    rst_n = 1'b1;
    run_txn(1'b0, 7'h00, 8'hCE, 8'h00);
    run_txn(1'b1, 7'h7F, 8'h3C, 8'hA5);
    run_txn(1'b0, 7'h05, 8'hCE, 8'h00);
    run_txn(1'b1, 7'h05, 8'h00, 8'hCE);
    // Back-to-back: req_valid stays high, second request waits for IDLE.
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h2A; req_wdata = 8'h5A;
    push_exp(1'b0, 7'h2A, 8'h5A, 8'h00);
    @(negedge clk);
    req_rw = 1'b1; req_wdata = 8'h99;
    n = 1; rise = -1; seen_low = 1'b0;
    while (!req_ready && n < 400) begin
      if (!cs_pin) seen_low = 1'b1;
      else if (seen_low && rise < 0) rise = n;
      @(negedge clk);
      n++;
    end
    chk("b2b_ready_low_span", n, 35 * CD + 1);
    push_exp(1'b1, 7'h2A, 8'h99, 8'h5A);
    @(negedge clk);
    n++;
    req_valid = 1'b0;
    while (cs_pin && n < 600) begin
      @(negedge clk);
      n++;
    end
    fall2 = n;
    chk("b2b_gap_ok", (rise > 0 && fall2 - rise >= CD + 1) ? 1 : 0, 1);
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second_done", req_ready, 1);
    // Abort a write during bit 5.
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h11; req_wdata = 8'h3C;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (45) @(negedge clk);
    snap = rsp_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_rdata = 8'h00;
    chk("abort_cs", cs_pin, 1);
    chk("abort_sclk", sclk_pin, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_rdata", rsp_rdata, 0);
    repeat (200) @(negedge clk);
    chk("abort_no_rsp", rsp_cnt, snap);
    run_txn(1'b1, 7'h05, 8'h00, 8'hCE);
    run_txn(1'b0, 7'h33, 8'h11, 8'h00);
    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
